// File: rtl/traffic_light_controller_rr.sv
// Round-robin traffic light controller: one highway against NUM_SIDE side roads.
// Define ALL_RED_EN to insert all-red clearance states after every yellow.
module traffic_light_controller_rr #(
  parameter int NUM_SIDE   = 2,
  parameter int CNT_W      = 16,
  parameter int T_HW_MIN   = 20,
  parameter int T_SIDE_MAX = 10,
  parameter int T_YELLOW   = 3,
  parameter int T_ALLRED   = 2
) (
  input  logic                                         clk,
  input  logic                                         rstn,
  input  logic [NUM_SIDE-1:0]                          sensor,
  output logic [2:0]                                   light_highway,
  output logic [3*NUM_SIDE-1:0]                        light_farmway,
  output logic [((NUM_SIDE > 1) ? $clog2(NUM_SIDE) : 1)-1:0] active_side
);

  localparam int SW = (NUM_SIDE > 1) ? $clog2(NUM_SIDE) : 1;

  localparam logic [CNT_W-1:0] HW_LAST   = CNT_W'(T_HW_MIN - 1);
  localparam logic [CNT_W-1:0] SIDE_LAST = CNT_W'(T_SIDE_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
`ifdef ALL_RED_EN
  localparam logic [CNT_W-1:0] RED_LAST  = CNT_W'(T_ALLRED - 1);
`endif

  typedef enum logic [2:0] {
    HW_GREEN    = 3'd0,
    HW_YELLOW   = 3'd1,
    SIDE_GREEN  = 3'd2,
    SIDE_YELLOW = 3'd3
`ifdef ALL_RED_EN
    ,
    RED1        = 3'd4,
    RED2        = 3'd5
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_SIDE-1:0] pend_q, pend_d;
  logic [SW-1:0]       active_q, active_d;
  logic [SW-1:0]       last_q, last_d;
  logic [SW-1:0]       pick;
  logic                found;
  int                  idx;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= HW_GREEN;
      cnt_q    <= '0;
      pend_q   <= '0;
      active_q <= '0;
      last_q   <= SW'(NUM_SIDE - 1);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      active_q <= active_d;
      last_q   <= last_d;
    end
  end

  // First pending road after the one served last, wrapping around.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_SIDE; k++) begin
      idx = (int'(last_q) + k) % NUM_SIDE;
      if (!found && pend_q[idx]) begin
        pick  = SW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q | sensor;
    active_d = active_q;
    last_d   = last_q;
    case (state_q)
      HW_GREEN: begin
        if (cnt_q >= HW_LAST && |pend_q) state_d = HW_YELLOW;
      end
      HW_YELLOW: begin
        if (cnt_q == YEL_LAST) begin
`ifdef ALL_RED_EN
          state_d = RED1;
`else
          state_d = SIDE_GREEN;
`endif
          active_d     = pick;
          last_d       = pick;
          pend_d[pick] = 1'b0;
        end
      end
      SIDE_GREEN: begin
        // The served road does not latch its own sensor unless it times out still occupied.
        pend_d[active_q] = pend_q[active_q];
        if (!sensor[active_q]) begin
          state_d = SIDE_YELLOW;
        end else if (cnt_q == SIDE_LAST) begin
          state_d          = SIDE_YELLOW;
          pend_d[active_q] = 1'b1;
        end
      end
      SIDE_YELLOW: begin
        if (cnt_q == YEL_LAST) begin
`ifdef ALL_RED_EN
          state_d = RED2;
`else
          state_d = HW_GREEN;
`endif
        end
      end
`ifdef ALL_RED_EN
      RED1: begin
        if (cnt_q == RED_LAST) state_d = SIDE_GREEN;
      end
      RED2: begin
        if (cnt_q == RED_LAST) state_d = HW_GREEN;
      end
`endif
      default: state_d = HW_GREEN;
    endcase

    if (state_d != state_q)   cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    light_highway = 3'b100;
    light_farmway = '0;
    case (state_q)
      HW_GREEN:  light_highway = 3'b001;
      HW_YELLOW: light_highway = 3'b010;
      default:   light_highway = 3'b100;
    endcase
    for (int i = 0; i < NUM_SIDE; i++) begin
      light_farmway[3*i +: 3] = 3'b100;
      if (SW'(i) == active_q) begin
        if (state_q == SIDE_GREEN)       light_farmway[3*i +: 3] = 3'b001;
        else if (state_q == SIDE_YELLOW) light_farmway[3*i +: 3] = 3'b010;
      end
    end
  end

  assign active_side = active_q;

endmodule

// File: tb/tb_traffic_light_controller_rr.sv
// Directed self-checking bench for traffic_light_controller_rr at default parameters.
// Expected lamp sequences are hand-built segment tables; ALL_RED_EN adds 2-cycle red segments.
module tb_traffic_light_controller_rr;

`ifdef ALL_RED_EN
  localparam int AR = 2;
`else
  localparam int AR = 0;
`endif

  localparam logic [2:0] HG = 3'b001;
  localparam logic [2:0] HY = 3'b010;
  localparam logic [2:0] HR = 3'b100;
  localparam logic [5:0] F_RED = 6'b100100;
  localparam logic [5:0] F0_G  = 6'b100001;
  localparam logic [5:0] F0_Y  = 6'b100010;
  localparam logic [5:0] F1_G  = 6'b001100;
  localparam logic [5:0] F1_Y  = 6'b010100;

  logic       clk;
  logic       rstn;
  logic [1:0] sensor;
  logic [2:0] light_highway;
  logic [5:0] light_farmway;
  logic [0:0] active_side;

  int testsRun;
  int testsFailed;

  traffic_light_controller_rr dut (
    .clk           (clk),
    .rstn          (rstn),
    .sensor        (sensor),
    .light_highway (light_highway),
    .light_farmway (light_farmway),
    .active_side   (active_side)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the bench at the negedge of cycle 0 (first cycle after reset).
  task automatic doReset();
    rstn   = 1'b0;
    sensor = 2'b00;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn   = 1'b0;
    sensor = 2'b11;
    repeat (10) @(negedge clk);
    testsRun++;
    if (light_highway !== HG || light_farmway !== F_RED || active_side !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_hold: hw=%b farm=%b act=%0d, expected hw=%b farm=%b act=0",
               light_highway, light_farmway, active_side, HG, F_RED);
    end

    doReset();
    sensor = 2'b10;
    repeat (23 + AR) @(negedge clk);
    testsRun++;
    if (light_highway !== HR || light_farmway !== F1_G || active_side !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_reach_side: hw=%b farm=%b act=%0d, expected hw=%b farm=%b act=1",
               light_highway, light_farmway, active_side, HR, F1_G);
    end
    rstn = 1'b0;
    @(negedge clk);
    testsRun++;
    if (light_highway !== HG || light_farmway !== F_RED || active_side !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_side: hw=%b farm=%b act=%0d, expected hw=%b farm=%b act=0",
               light_highway, light_farmway, active_side, HG, F_RED);
    end
    rstn   = 1'b1;
    sensor = 2'b00;
    repeat (25) @(negedge clk);
    testsRun++;
    if (light_highway !== HG || light_farmway !== F_RED) begin
      testsFailed++;
      $display("[TB] FAIL reset_pend_cleared: hw=%b farm=%b, expected hw=%b farm=%b",
               light_highway, light_farmway, HG, F_RED);
    end
  endtask

  task automatic test_latched_pulse();
    int         segLen[7];
    logic [2:0] segHw[7];
    logic [5:0] segFarm[7];
    int         cyc;
    segLen  = '{20, 3, AR, 1, 3, AR, 5};
    segHw   = '{HG, HY, HR, HR, HR, HR, HG};
    segFarm = '{F_RED, F_RED, F_RED, F0_G, F0_Y, F_RED, F_RED};
    doReset();
    cyc = 0;
    for (int s = 0; s < 7; s++) begin
      for (int k = 0; k < segLen[s]; k++) begin
        testsRun++;
        if (light_highway !== segHw[s] || light_farmway !== segFarm[s] || active_side !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL pulse cycle %0d: hw=%b farm=%b act=%0d, expected hw=%b farm=%b act=0",
                   cyc, light_highway, light_farmway, active_side, segHw[s], segFarm[s]);
        end
        sensor = (cyc == 5) ? 2'b01 : 2'b00;
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic test_timeout_requeue();
    int         segLen[14];
    logic [2:0] segHw[14];
    logic [5:0] segFarm[14];
    logic       segAct[14];
    logic [1:0] segSen[14];
    int         cyc;
    segLen  = '{20, 3, AR, 10, 3, AR, 20, 3, AR, 1, 3, AR, 3, 0};
    segHw   = '{HG, HY, HR, HR, HR, HR, HG, HY, HR, HR, HR, HR, HG, HG};
    segFarm = '{F_RED, F_RED, F_RED, F1_G, F1_Y, F_RED, F_RED, F_RED, F_RED,
                F1_G, F1_Y, F_RED, F_RED, F_RED};
    segAct  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    segSen  = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    doReset();
    cyc = 0;
    for (int s = 0; s < 14; s++) begin
      for (int k = 0; k < segLen[s]; k++) begin
        testsRun++;
        if (light_highway !== segHw[s] || light_farmway !== segFarm[s] || active_side !== segAct[s]) begin
          testsFailed++;
          $display("[TB] FAIL timeout cycle %0d: hw=%b farm=%b act=%0d, expected hw=%b farm=%b act=%0d",
                   cyc, light_highway, light_farmway, active_side, segHw[s], segFarm[s], segAct[s]);
        end
        sensor = segSen[s];
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic test_round_robin();
    int         segLen[16];
    logic [2:0] segHw[16];
    logic [5:0] segFarm[16];
    logic       segAct[16];
    int         cyc;
    segLen  = '{20, 3, AR, 10, 3, AR, 20, 3, AR, 10, 3, AR, 20, 3, AR, 10};
    segHw   = '{HG, HY, HR, HR, HR, HR, HG, HY, HR, HR, HR, HR, HG, HY, HR, HR};
    segFarm = '{F_RED, F_RED, F_RED, F0_G, F0_Y, F_RED, F_RED, F_RED, F_RED,
                F1_G, F1_Y, F_RED, F_RED, F_RED, F_RED, F0_G};
    segAct  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    doReset();
    cyc = 0;
    for (int s = 0; s < 16; s++) begin
      for (int k = 0; k < segLen[s]; k++) begin
        testsRun++;
        if (light_highway !== segHw[s] || light_farmway !== segFarm[s] || active_side !== segAct[s]) begin
          testsFailed++;
          $display("[TB] FAIL roundrobin cycle %0d: hw=%b farm=%b act=%0d, expected hw=%b farm=%b act=%0d",
                   cyc, light_highway, light_farmway, active_side, segHw[s], segFarm[s], segAct[s]);
        end
        sensor = 2'b11;
        @(negedge clk);
        cyc++;
      end
    end
    sensor = 2'b00;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rstn        = 1'b0;
    sensor      = 2'b00;
    @(negedge clk);
    test_reset();
    test_latched_pulse();
    test_timeout_requeue();
    test_round_robin();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
